// File: rtl/instruction_streamer.sv
// Program sequencer: loadable program memory issuing one word per slot to the cpu.
// Latency: start sampled at edge N, first word registered at edge N+1; one word per ISSUE_GAP clocks.
// Backpressure: none from cpu; inserts NOPs after a tensor operate until tensor_done_in.
module instruction_streamer #(
    parameter int                     INSTR_WIDTH     = 16,
    parameter int                     DEPTH           = 1024,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD       = 16'hFFFF,
    parameter int                     ISSUE_GAP       = 1,
    parameter bit                     STALL_ON_TENSOR = 1'b1
) (
    input  logic                       clock_in,
    input  logic                       reset_in,
    input  logic                       load_enable_in,
    input  logic [$clog2(DEPTH)-1:0]   load_address_in,
    input  logic [INSTR_WIDTH-1:0]     load_data_in,
    input  logic                       start_in,
    input  logic                       abort_in,
    input  logic                       tensor_done_in,
    output logic [INSTR_WIDTH-1:0]     current_instruction,
    output logic                       instruction_valid,
    output logic [$clog2(DEPTH)-1:0]   program_counter,
    output logic                       running,
    output logic                       halted,
    output logic                       overflow,
    output logic [15:0]                retired_count,
    output logic [31:0]                cycle_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] OP_TENSOR_OPERATE = 4'b1001;
    // GAP holds for ISSUE_GAP-1 cycles: the counter is loaded with ISSUE_GAP-2 and exits at zero
    localparam int GW = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;
    localparam int GAP_LOAD_I = (ISSUE_GAP > 1) ? ISSUE_GAP - 2 : 0;
    localparam logic [GW-1:0] GAP_LOAD = GAP_LOAD_I[GW-1:0];
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT_TENSOR,
        S_HALTED
    } state_t;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic [AW-1:0]          pc_q, pc_d;
    logic [15:0]            retired_q, retired_d;
    logic [31:0]            cycle_q, cycle_d;
    logic                   overflow_q, overflow_d;
    logic                   at_end_q, at_end_d;    // last issued word came from LAST_ADDR
    logic [GW-1:0]          gap_q, gap_d;
    logic                   running_q, running_d;
    logic                   halted_q, halted_d;

    logic [INSTR_WIDTH-1:0] rd_word;
    logic                   is_running;
    logic                   next_running;

    // Program writes are accepted only while not executing; memory itself is never reset
    always_ff @(posedge clock_in) begin
        if (load_enable_in && (state_q == S_IDLE || state_q == S_HALTED)) begin
            mem[load_address_in] <= load_data_in;
        end
    end

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d    = state_q;
        instr_d    = '0;
        valid_d    = 1'b0;
        pc_d       = pc_q;
        retired_d  = retired_q;
        cycle_d    = cycle_q;
        overflow_d = overflow_q;
        at_end_d   = at_end_q;
        gap_d      = gap_q;
        rd_word    = mem[pc_q];
        is_running = (state_q == S_ISSUE) || (state_q == S_GAP) || (state_q == S_WAIT_TENSOR);

        if (abort_in && is_running) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start_in && !abort_in) begin
                        state_d    = S_ISSUE;
                        pc_d       = '0;
                        retired_d  = '0;
                        cycle_d    = '0;
                        overflow_d = 1'b0;
                        at_end_d   = 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (rd_word == HALT_WORD) begin
                        state_d = S_HALTED;
                    end else begin
                        instr_d  = rd_word;
                        valid_d  = 1'b1;
                        pc_d     = (pc_q == LAST_ADDR) ? '0 : pc_q + 1'b1;
                        at_end_d = (pc_q == LAST_ADDR);
                        if (retired_q != 16'hFFFF) begin
                            retired_d = retired_q + 16'd1;
                        end
                        if (STALL_ON_TENSOR && rd_word[INSTR_WIDTH-1 -: 4] == OP_TENSOR_OPERATE) begin
                            state_d = S_WAIT_TENSOR;
                        end else if (ISSUE_GAP > 1) begin
                            state_d = S_GAP;
                            gap_d   = GAP_LOAD;
                        end else if (pc_q == LAST_ADDR) begin
                            state_d    = S_HALTED;
                            overflow_d = 1'b1;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        if (at_end_q) begin
                            state_d    = S_HALTED;
                            overflow_d = 1'b1;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                S_WAIT_TENSOR: begin
                    if (tensor_done_in) begin
                        if (ISSUE_GAP > 1) begin
                            state_d = S_GAP;
                            gap_d   = GAP_LOAD;
                        end else if (at_end_q) begin
                            state_d    = S_HALTED;
                            overflow_d = 1'b1;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        next_running = (state_d == S_ISSUE) || (state_d == S_GAP) || (state_d == S_WAIT_TENSOR);
        // The cycle that leaves the running states (halt, overflow, abort) is not counted
        if (is_running && next_running) begin
            cycle_d = cycle_q + 32'd1;
        end
        running_d = next_running;
        halted_d  = (state_d == S_HALTED);
    end

    // State and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            retired_q  <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            at_end_q   <= 1'b0;
            gap_q      <= '0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            at_end_q   <= at_end_d;
            gap_q      <= gap_d;
            running_q  <= running_d;
            halted_q   <= halted_d;
        end
    end

    assign current_instruction = instr_q;
    assign instruction_valid   = valid_q;
    assign program_counter     = pc_q;
    assign running             = running_q;
    assign halted              = halted_q;
    assign overflow            = overflow_q;
    assign retired_count       = retired_q;
    assign cycle_count         = cycle_q;

endmodule

// File: tb/tb_instruction_streamer.sv
// Bench for instruction_streamer: three instances (default, ISSUE_GAP=2, DEPTH=4).
// Expected words are queued when a program is started and popped as each instance issues.
// Every cycle a non-valid output is also required to be NOP.
module tb_instruction_streamer;

    logic        clk;
    logic        rst;
    logic        load_en_a, load_en_g, load_en_o;
    logic [9:0]  load_addr;
    logic [15:0] load_data;
    logic        start_a, start_g, start_o;
    logic        abort_a, tdone_a;

    logic [15:0] a_instr, g_instr, o_instr;
    logic        a_valid, g_valid, o_valid;
    logic [9:0]  a_pc, g_pc;
    logic [1:0]  o_pc;
    logic        a_running, g_running, o_running;
    logic        a_halted, g_halted, o_halted;
    logic        a_ovf, g_ovf, o_ovf;
    logic [15:0] a_ret, g_ret, o_ret;
    logic [31:0] a_cyc, g_cyc, o_cyc;

    logic [15:0] q_a[$];
    logic [15:0] q_g[$];
    logic [15:0] q_o[$];

    int n_cmp  = 0;
    int n_fail = 0;

    instruction_streamer u_a (
        .clock_in(clk), .reset_in(rst),
        .load_enable_in(load_en_a), .load_address_in(load_addr), .load_data_in(load_data),
        .start_in(start_a), .abort_in(abort_a), .tensor_done_in(tdone_a),
        .current_instruction(a_instr), .instruction_valid(a_valid), .program_counter(a_pc),
        .running(a_running), .halted(a_halted), .overflow(a_ovf),
        .retired_count(a_ret), .cycle_count(a_cyc)
    );

    instruction_streamer #(.ISSUE_GAP(2)) u_g (
        .clock_in(clk), .reset_in(rst),
        .load_enable_in(load_en_g), .load_address_in(load_addr), .load_data_in(load_data),
        .start_in(start_g), .abort_in(1'b0), .tensor_done_in(1'b0),
        .current_instruction(g_instr), .instruction_valid(g_valid), .program_counter(g_pc),
        .running(g_running), .halted(g_halted), .overflow(g_ovf),
        .retired_count(g_ret), .cycle_count(g_cyc)
    );

    instruction_streamer #(.DEPTH(4)) u_o (
        .clock_in(clk), .reset_in(rst),
        .load_enable_in(load_en_o), .load_address_in(load_addr[1:0]), .load_data_in(load_data),
        .start_in(start_o), .abort_in(1'b0), .tensor_done_in(1'b0),
        .current_instruction(o_instr), .instruction_valid(o_valid), .program_counter(o_pc),
        .running(o_running), .halted(o_halted), .overflow(o_ovf),
        .retired_count(o_ret), .cycle_count(o_cyc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score every instance's output for that cycle
    task automatic tick();
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (a_valid) begin
            if (q_a.size() > 0) begin e = q_a.pop_front(); check("a_word", a_instr, e); end
            else check("a_unexpected_valid", a_valid, 0);
        end else check("a_nop", a_instr, 0);
        if (g_valid) begin
            if (q_g.size() > 0) begin e = q_g.pop_front(); check("g_word", g_instr, e); end
            else check("g_unexpected_valid", g_valid, 0);
        end else check("g_nop", g_instr, 0);
        if (o_valid) begin
            if (q_o.size() > 0) begin e = q_o.pop_front(); check("o_word", o_instr, e); end
            else check("o_unexpected_valid", o_valid, 0);
        end else check("o_nop", o_instr, 0);
    endtask

    task automatic load(input logic ea, input logic eg, input logic eo,
                        input logic [9:0] addr, input logic [15:0] data);
        load_en_a = ea; load_en_g = eg; load_en_o = eo;
        load_addr = addr; load_data = data;
        tick();
        load_en_a = 1'b0; load_en_g = 1'b0; load_en_o = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        load_en_a = 1'b0; load_en_g = 1'b0; load_en_o = 1'b0;
        load_addr = '0; load_data = '0;
        start_a = 1'b0; start_g = 1'b0; start_o = 1'b0;
        abort_a = 1'b0; tdone_a = 1'b0;

        // Reset values
        #1 rst = 1'b1;
        #1;
        check("rst_instr", a_instr, 0);
        check("rst_valid", a_valid, 0);
        check("rst_pc", a_pc, 0);
        check("rst_running", a_running, 0);
        check("rst_halted", a_halted, 0);
        check("rst_overflow", a_ovf, 0);
        check("rst_retired", a_ret, 0);
        check("rst_cycle", a_cyc, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic stream on the default instance (gap instance gets the same program)
        load(1, 1, 0, 10'd0, 16'h6105);
        load(1, 1, 0, 10'd1, 16'h6203);
        load(1, 1, 0, 10'd2, 16'h2312);
        load(1, 1, 0, 10'd3, 16'hFFFF);
        q_a.push_back(16'h6105); q_a.push_back(16'h6203); q_a.push_back(16'h2312);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("basic_start_latency", a_valid, 0);
        check("basic_running", a_running, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("basic_valid", a_valid, 1);
        end
        tick();
        check("basic_end_valid", a_valid, 0);
        check("basic_halted", a_halted, 1);
        check("basic_retired", a_ret, 3);
        check("basic_pc", a_pc, 3);
        check("basic_not_running", a_running, 0);

        // Issue gap of 2: valid on alternate cycles
        q_g.push_back(16'h6105); q_g.push_back(16'h6203); q_g.push_back(16'h2312);
        start_g = 1'b1;
        tick();
        start_g = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("gap_valid", g_valid, (i % 2 == 0 && i < 6) ? 1 : 0);
        end
        check("gap_halted", g_halted, 1);
        check("gap_cycle", g_cyc, 6);
        check("gap_retired", g_ret, 3);

        // Tensor stall
        load(1, 0, 0, 10'd0, 16'h9000);
        load(1, 0, 0, 10'd1, 16'h8001);
        load(1, 0, 0, 10'd2, 16'hFFFF);
        q_a.push_back(16'h9000); q_a.push_back(16'h8001);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        check("stall_operate_valid", a_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_wait_valid", a_valid, 0);
            check("stall_wait_running", a_running, 1);
        end
        tdone_a = 1'b1;
        tick();
        check("stall_done_edge_valid", a_valid, 0);
        tdone_a = 1'b0;
        tick();
        check("stall_resume_valid", a_valid, 1);
        tick();
        check("stall_halted", a_halted, 1);
        check("stall_retired", a_ret, 2);

        // Overflow on DEPTH=4 with no sentinel
        load(0, 0, 1, 10'd0, 16'h1111);
        load(0, 0, 1, 10'd1, 16'h2222);
        load(0, 0, 1, 10'd2, 16'h3333);
        load(0, 0, 1, 10'd3, 16'h4444);
        q_o.push_back(16'h1111); q_o.push_back(16'h2222);
        q_o.push_back(16'h3333); q_o.push_back(16'h4444);
        start_o = 1'b1;
        tick();
        start_o = 1'b0;
        check("ovf_start_latency", o_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ovf_valid", o_valid, 1);
        end
        check("ovf_halted", o_halted, 1);
        check("ovf_flag", o_ovf, 1);
        check("ovf_pc_wrap", o_pc, 0);
        check("ovf_retired", o_ret, 4);
        tick();
        check("ovf_after_valid", o_valid, 0);

        // Abort with simultaneous start, and a load dropped while running
        load(1, 0, 0, 10'd0, 16'h1A01);
        load(1, 0, 0, 10'd1, 16'h1A02);
        load(1, 0, 0, 10'd2, 16'h1A03);
        load(1, 0, 0, 10'd3, 16'h1A04);
        load(1, 0, 0, 10'd4, 16'h1A05);
        load(1, 0, 0, 10'd5, 16'hFFFF);
        q_a.push_back(16'h1A01); q_a.push_back(16'h1A02);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        load(1, 0, 0, 10'd3, 16'hBEEF);
        abort_a = 1'b1; start_a = 1'b1;
        tick();
        abort_a = 1'b0; start_a = 1'b0;
        check("abort_valid", a_valid, 0);
        check("abort_running", a_running, 0);
        check("abort_halted", a_halted, 0);
        check("abort_retired_hold", a_ret, 2);
        check("abort_pc_hold", a_pc, 2);
        tick();
        check("abort_stays_idle", a_running, 0);
        q_a.push_back(16'h1A01); q_a.push_back(16'h1A02); q_a.push_back(16'h1A03);
        q_a.push_back(16'h1A04); q_a.push_back(16'h1A05);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rerun_valid", a_valid, 1);
        end
        tick();
        check("rerun_halted", a_halted, 1);
        check("rerun_retired", a_ret, 5);

        // Asynchronous reset in the middle of a tensor stall
        load(1, 0, 0, 10'd0, 16'h9000);
        load(1, 0, 0, 10'd1, 16'hFFFF);
        q_a.push_back(16'h9000);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        check("areset_pre_running", a_running, 1);
        #2 rst = 1'b1;
        #1;
        check("areset_instr", a_instr, 0);
        check("areset_valid", a_valid, 0);
        check("areset_running", a_running, 0);
        check("areset_retired", a_ret, 0);
        check("areset_pc", a_pc, 0);
        check("areset_cycle", a_cyc, 0);
        #1 rst = 1'b0;
        tick();
        check("areset_idle_running", a_running, 0);
        check("areset_idle_halted", a_halted, 0);

        check("a_queue_drained", q_a.size(), 0);
        check("g_queue_drained", q_g.size(), 0);
        check("o_queue_drained", q_o.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
